id_ex_stage: RTL

//  ID/EX pipeline register plus EX operand forwarding. Sits directly upstream of the ALU.

---
 rtl/id_ex_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding from EX/MEM and MEM/WB.
// Forwarding is built only when EX_FORWARD_EN is defined; otherwise the hazard unit must stall.
`ifndef ALU_ADD
`define ALU_ADD 4'd2
`endif
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [31:0]           id_pc,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [4:0]            id_shamt,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_src_a_sel,
  input  logic                  id_src_b_sel,
  input  logic [REG_ADDR_W-1:0] id_dest_addr,
  input  logic                  id_reg_write,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_dest_addr,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dest_addr,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [DATA_W-1:0]     alu_input_a,
  output logic [DATA_W-1:0]     alu_input_b,
  output logic [3:0]            alu_operation,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc,
  output logic [REG_ADDR_W-1:0] ex_dest_addr,
  output logic                  ex_reg_write,
  output logic [DATA_W-1:0]     ex_store_data
);
  logic [DATA_W-1:0]     rs_q, rt_q, imm_q, fa, fb;
  logic [REG_ADDR_W-1:0] rs_addr_q, rt_addr_q;
  logic [4:0]            shamt_q;
  logic                  src_a_sel_q, src_b_sel_q;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_dest_addr  <= '0;
      ex_reg_write  <= 1'b0;
      alu_operation <= `ALU_ADD;
      rs_q          <= '0;
      rt_q          <= '0;
      imm_q         <= '0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      shamt_q       <= '0;
      src_a_sel_q   <= 1'b0;
      src_b_sel_q   <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_dest_addr  <= id_dest_addr;
      ex_reg_write  <= id_reg_write & id_valid;
      alu_operation <= id_alu_op;
      rs_q          <= id_rs_data;
      rt_q          <= id_rt_data;
      imm_q         <= id_imm;
      rs_addr_q     <= id_rs_addr;
      rt_addr_q     <= id_rt_addr;
      shamt_q       <= id_shamt;
      src_a_sel_q   <= id_src_a_sel;
      src_b_sel_q   <= id_src_b_sel;
    end
  end
`ifdef EX_FORWARD_EN
  logic mem_fwd_ok, wb_fwd_ok;
  // $0 is hardwired zero, so a write targeting it must never be forwarded
  assign mem_fwd_ok = mem_reg_write && mem_dest_addr != '0;
  assign wb_fwd_ok  = wb_reg_write && wb_dest_addr != '0;
  always_comb begin
    fa = (mem_fwd_ok && mem_dest_addr == rs_addr_q) ? mem_result :
         (wb_fwd_ok && wb_dest_addr == rs_addr_q) ? wb_result : rs_q;
    fb = (mem_fwd_ok && mem_dest_addr == rt_addr_q) ? mem_result :
         (wb_fwd_ok && wb_dest_addr == rt_addr_q) ? wb_result : rt_q;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_reg_write, mem_dest_addr, mem_result, wb_reg_write, wb_dest_addr,
                        wb_result, rs_addr_q, rt_addr_q};
  always_comb begin
    fa = rs_q;
    fb = rt_q;
  end
`endif
  assign alu_input_a   = src_a_sel_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fa;
  assign alu_input_b   = src_b_sel_q ? imm_q : fb;
  assign ex_store_data = fb;
endmodule
